// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
// State encoding and gate-window sizing helpers.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } state_t;

    // Number of clkIn cycles in one gate window
    function automatic int gate_len(input int clk_hz, input int gate_div);
        return clk_hz / gate_div;
    endfunction

    // Bits needed to count 0 .. len-1
    function automatic int gate_w(input int len);
        return (len < 3) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge pulse.
// Generic for any asynchronous single-bit input.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1, s2, s3;

    // Metastability filter plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts sigIn rising edges per gate window.
// Results are scaled by GATE_DIV and saturate at full scale.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int GATE_DIV = 1,
    parameter int CNT_W    = 26
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic             en,
    input  logic             sigIn,
    output logic [CNT_W-1:0] freqOut,
    output logic             freqValid,
    output logic             overflow,
    output logic             busy
);

    localparam int GATE_LEN = gate_len(CLK_HZ, GATE_DIV);
    localparam int GW       = gate_w(GATE_LEN);
    localparam int DW       = $clog2(GATE_DIV);
    localparam int PW       = CNT_W + DW + 1;

    localparam logic [GW-1:0]    LAST    = GW'(GATE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (GATE_LEN < 2) begin : g_len_check
        $error("freq_meter: gate window must be at least 2 cycles");
    end

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             edge_ovf;
    logic             edge_p;

    logic [CNT_W:0]   sum;
    logic             sum_ovf;
    logic [CNT_W-1:0] sum_sat;
    logic [PW-1:0]    prod;
    logic             prod_big;
    logic [CNT_W-1:0] scaled;

    sync_edge u_sync (
        .clk   (clkIn),
        .rst   (rst),
        .din   (sigIn),
        .pulse (edge_p)
    );

    // Final-cycle total including this cycle's edge, then scale and clamp
    always_comb begin
        sum      = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, edge_p};
        sum_ovf  = edge_ovf | sum[CNT_W];
        sum_sat  = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
        prod     = PW'(sum_sat) * PW'(GATE_DIV);
        prod_big = prod > PW'(CNT_MAX);
        scaled   = prod_big ? CNT_MAX : prod[CNT_W-1:0];
    end

    // Control FSM with gate/edge counters and registered results
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            edge_ovf  <= 1'b0;
            freqOut   <= '0;
            freqValid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            freqValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    edge_ovf <= 1'b0;
                    if (en) begin
                        state <= GATE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GATE: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gate_cnt == LAST) begin
                        freqOut   <= scaled;
                        overflow  <= prod_big | sum_ovf;
                        freqValid <= 1'b1;
                        gate_cnt  <= '0;
                        edge_cnt  <= '0;
                        edge_ovf  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        if (edge_p) begin
                            if (edge_cnt == CNT_MAX) begin
                                edge_ovf <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter with a window-counting reference model.
// Two instances: full-width counter and a narrow 8-bit one.
module tb_freq_meter;

    localparam int GL  = 100;
    localparam int GD  = 10;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst, en, sig, en8, sig8;
    logic [25:0] fo;
    logic        fv, ov, bz;
    logic [7:0]  fo8;
    logic        fv8, ov8, bz8;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;
    int nv0    = -1;
    int nv1    = -1;
    int q0[$];
    int q1[$];
    int mode0, per0, ph0;
    int mode1, per1, ph1;

    always #5 clk = ~clk;

    freq_meter #(.CLK_HZ(1000), .GATE_DIV(GD), .CNT_W(26)) dut (
        .clkIn     (clk),
        .rst       (rst),
        .en        (en),
        .sigIn     (sig),
        .freqOut   (fo),
        .freqValid (fv),
        .overflow  (ov),
        .busy      (bz)
    );

    freq_meter #(.CLK_HZ(1000), .GATE_DIV(GD), .CNT_W(8)) dut8 (
        .clkIn     (clk),
        .rst       (rst),
        .en        (en8),
        .sigIn     (sig8),
        .freqOut   (fo8),
        .freqValid (fv8),
        .overflow  (ov8),
        .busy      (bz8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Rising edges of the stimulus that fall within [lo, hi]
    function automatic int cnt(input int which, input int lo, input int hi);
        int n = 0;
        if (which == 0) begin
            foreach (q0[i]) if (q0[i] >= lo && q0[i] <= hi) n++;
        end else begin
            foreach (q1[i]) if (q1[i] >= lo && q1[i] <= hi) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] sat(input int n, input int w);
        longint v = longint'(n) * GD;
        longint m = (longint'(1) << w) - 1;
        return (v > m) ? 32'(m) : 32'(v);
    endfunction

    function automatic logic ovf_exp(input int n, input int w);
        return (longint'(n) * GD) > ((longint'(1) << w) - 1);
    endfunction

    function automatic logic gen(input int mode, input int per,
                                 input int ph, input int c);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ((c + ph) % per) < (per / 2);
    endfunction

    task automatic step();
        logic nx;
        int   n;
        @(posedge clk);
        cyc++;
        #1;
        chk("valid", 32'(fv), 32'(cyc == nv0));
        if (fv && cyc == nv0) begin
            n = cnt(0, cyc - GL + 1 - LAT, cyc - LAT);
            chk("freq", 32'(fo), sat(n, 26));
            chk("ovf", 32'(ov), 32'(ovf_exp(n, 26)));
            nv0 += GL;
        end
        chk("valid8", 32'(fv8), 32'(cyc == nv1));
        if (fv8 && cyc == nv1) begin
            n = cnt(1, cyc - GL + 1 - LAT, cyc - LAT);
            chk("freq8", 32'(fo8), sat(n, 8));
            chk("ovf8", 32'(ov8), 32'(ovf_exp(n, 8)));
            nv1 += GL;
        end
        nx = gen(mode0, per0, ph0, cyc);
        if (nx && !sig) q0.push_back(cyc);
        sig = nx;
        nx = gen(mode1, per1, ph1, cyc);
        if (nx && !sig8) q1.push_back(cyc);
        sig8 = nx;
    endtask

    initial begin
        int ac_from, first_e, last_e, acc;
        rst = 1'b1; en = 1'b0; sig = 1'b0; en8 = 1'b0; sig8 = 1'b0;
        mode0 = 0; per0 = 10; ph0 = 0;
        mode1 = 0; per1 = 10; ph1 = 0;

        // reset state
        repeat (3) step();
        chk("rst_freq", 32'(fo), 0);
        chk("rst_ovf", 32'(ov), 0);
        chk("rst_busy", 32'(bz), 0);
        chk("rst_freq8", 32'(fo8), 0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_busy", 32'(bz), 0);

        // period 10 -> 100 Hz scaled
        mode0 = 2; per0 = 10; ph0 = 0;
        en = 1'b1;
        nv0 = cyc + GL + 2;
        step();
        chk("arm_busy", 32'(bz), 1);
        repeat (350) step();
        chk("t1_freq", 32'(fo), 100);
        chk("t1_ovf", 32'(ov), 0);

        // abort mid-window, then restart
        for (int i = 0; i < GL && cyc < nv0 - GL + 50; i++) step();
        en = 1'b0;
        nv0 = -1;
        step();
        chk("t4_busy", 32'(bz), 0);
        repeat (150) step();
        chk("t4_hold", 32'(fo), 100);
        en = 1'b1;
        nv0 = cyc + GL + 2;
        repeat (210) step();
        chk("t4_freq", 32'(fo), 100);

        // constant input levels
        mode0 = 0;
        repeat (300) step();
        chk("t2_low", 32'(fo), 0);
        mode0 = 1;
        repeat (300) step();
        chk("t2_high", 32'(fo), 0);
        chk("t2_ovf", 32'(ov), 0);

        // asynchronous reset in the middle of a window
        mode0 = 2; per0 = 10;
        repeat (250) step();
        @(posedge clk);
        cyc++;
        #3;
        rst = 1'b1;
        mode0 = 0;
        sig = 1'b0;
        nv0 = -1;
        #1;
        chk("t5_freq", 32'(fo), 0);
        chk("t5_valid", 32'(fv), 0);
        chk("t5_busy", 32'(bz), 0);
        repeat (5) step();
        rst = 1'b0;
        nv0 = cyc + GL + 2;
        mode0 = 2; per0 = 10;
        repeat (210) step();
        chk("t5_after", 32'(fo), 100);

        // period 7, random phase: 14 or 15 edges per window
        mode0 = 2; per0 = 7; ph0 = $urandom_range(0, 6);
        step();
        ac_from = nv0 + 2 * GL;
        first_e = -1; last_e = -1; acc = 0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (fv && cyc >= ac_from) begin
                chk("t6_set", 32'(fo == 140 || fo == 150), 1);
                if (first_e < 0) first_e = cyc;
                last_e = cyc;
                acc += int'(fo) / GD;
            end
        end
        chk("t6_sum", 32'(acc),
            32'(cnt(0, first_e - GL + 1 - LAT, last_e - LAT)));

        // random periods
        for (int r = 0; r < 4; r++) begin
            per0 = $urandom_range(3, 25);
            ph0  = $urandom_range(0, 24);
            repeat (250) step();
        end

        // narrow counter: saturation then recovery
        mode1 = 2; per1 = 2; ph1 = 0;
        en8 = 1'b1;
        nv1 = cyc + GL + 2;
        repeat (250) step();
        chk("t3_sat", 32'(fo8), 255);
        chk("t3_ovf", 32'(ov8), 1);
        per1 = 20;
        repeat (250) step();
        chk("t3_freq", 32'(fo8), 50);
        chk("t3_novf", 32'(ov8), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
